// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store front end.
//   - request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
//   - FSM state enum (IDLE, RD, WR, RESP)
//   - MMIO_BASE: base of the 1 KiB IO window (used only when MMIO_EN is defined)
//   - request legality and IO-window decode helpers
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // True when the size is reserved or the address is not naturally aligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // True when the byte address lies in the IO window (upper 22 bits all ones).
  function automatic logic addr_is_mmio(input logic [31:0] addr);
    return (addr[31:10] == MMIO_BASE[31:10]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   Ports:
//     size        in  2   request size (mem_pkg SZ_*)
//     lo          in  2   byte address bits [1:0]
//     is_unsigned in  1   zero-extend sub-word loads
//     word        in  32  word read from memory / IO
//     store_data  in  32  right-aligned store data
//     load_data   out 32  lane extracted and sign/zero-extended
//     merged      out 32  word with the addressed lane replaced by store_data
//   Little-endian: byte lane k = bits 8k+7:8k, half lane h = bits 16h+15:16h.
import mem_pkg::*;

module lsu_align (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        sign_s;

  // Load path: pick the addressed lane and extend it.
  always_comb begin
    byte_s    = word[{lo, 3'b000} +: 8];
    half_s    = word[{lo[1], 4'b0000} +: 16];
    sign_s    = 1'b0;
    load_data = word;
    case (size)
      SZ_BYTE: begin
        sign_s    = ~is_unsigned & byte_s[7];
        load_data = {{24{sign_s}}, byte_s};
      end
      SZ_HALF: begin
        sign_s    = ~is_unsigned & half_s[15];
        load_data = {{16{sign_s}}, half_s};
      end
      default: begin
        load_data = word;
      end
    endcase
  end

  // Store path: overwrite only the addressed lane of the read word.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lo, 3'b000} +: 8]     = store_data[7:0];
      SZ_HALF: merged[{lo[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end between the execute stage and a
// word-wide, falling-edge-sampling data RAM.
//   Request side : req_valid/req_ready handshake, req_we, req_size,
//                  req_unsigned, req_addr (byte), req_wdata (right-aligned)
//   Response side: resp_valid (1-cycle pulse), resp_rdata, resp_err
//   RAM side     : mem_read, mem_write, mem_addr (word index), mem_wdata, mem_rdata
//   Optional macro MMIO_EN adds io_write, io_addr, io_wdata, io_rdata and
//   routes word accesses in the top 1 KiB of the address space to IO.
// Sub-word stores run as read-modify-write (RD then WR). Illegal requests go
// straight to RESP with resp_err and never touch memory. All outputs are
// registered: the next-state logic also computes next output values.
import mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MMIO_EN
  ,
  output logic              io_write,
  output logic [9:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
`endif
);

  state_t            state_r, state_s;
  logic              we_r, uns_r, io_r;
  logic [1:0]        size_r, lo_r;
  logic [DATA_W-1:0] wdata_r;

  logic              accept_s, bad_s, io_s;
  logic              ready_s, resp_valid_s, resp_err_s, mem_read_s, mem_write_s;
  logic [DATA_W-1:0] resp_rdata_s, mem_wdata_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] word_in_s, load_data_s, merged_s;

`ifdef MMIO_EN
  logic              io_write_s;
  logic [9:0]        io_addr_s;
  logic [DATA_W-1:0] io_wdata_s;

  assign io_s      = addr_is_mmio(req_addr);
  assign word_in_s = io_r ? io_rdata : mem_rdata;
`else
  // Without the IO window the address bits above the RAM index are don't-care.
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr[31:ADDR_W+2];
  assign io_s          = 1'b0;
  assign word_in_s     = mem_rdata;
`endif

  assign accept_s = req_valid & req_ready;
  // IO is word-only; any other size in the window is an error.
  assign bad_s    = req_is_bad(req_size, req_addr[1:0]) | (io_s & (req_size != SZ_WORD));

  lsu_align u_align (
    .size        (size_r),
    .lo          (lo_r),
    .is_unsigned (uns_r),
    .word        (word_in_s),
    .store_data  (wdata_r),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

  // Capture the request fields at the accept edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      io_r    <= 1'b0;
      size_r  <= 2'b00;
      lo_r    <= 2'b00;
      wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      we_r    <= req_we;
      uns_r   <= req_unsigned;
      io_r    <= io_s;
      size_r  <= req_size;
      lo_r    <= req_addr[1:0];
      wdata_r <= req_wdata;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_s      = state_r;
    ready_s      = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = {DATA_W{1'b0}};
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
`ifdef MMIO_EN
    io_write_s   = 1'b0;
    io_addr_s    = io_addr;
    io_wdata_s   = io_wdata;
`endif
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (accept_s) begin
          ready_s = 1'b0;
          if (bad_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else if (!req_we || (req_size != SZ_WORD)) begin
            // Loads and sub-word stores both start with a read.
            state_s    = RD;
            mem_read_s = ~io_s;
            mem_addr_s = io_s ? mem_addr : req_addr[ADDR_W+1:2];
`ifdef MMIO_EN
            io_addr_s  = io_s ? req_addr[9:0] : io_addr;
`endif
          end else begin
            state_s     = WR;
            mem_write_s = ~io_s;
            mem_addr_s  = io_s ? mem_addr : req_addr[ADDR_W+1:2];
            mem_wdata_s = io_s ? mem_wdata : req_wdata;
`ifdef MMIO_EN
            io_write_s  = io_s;
            io_addr_s   = io_s ? req_addr[9:0] : io_addr;
            io_wdata_s  = io_s ? req_wdata : io_wdata;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        // The read word is valid at the edge that ends this cycle.
        if (we_r) begin
          state_s     = WR;
          mem_write_s = 1'b1;
          mem_wdata_s = merged_s;
        end else begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = load_data_s;
        end
      end
      WR: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
`ifdef MMIO_EN
      io_write   <= 1'b0;
      io_addr    <= 10'd0;
      io_wdata   <= {DATA_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      req_ready  <= ready_s;
      resp_valid <= resp_valid_s;
      resp_err   <= resp_err_s;
      resp_rdata <= resp_rdata_s;
      mem_read   <= mem_read_s;
      mem_write  <= mem_write_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
`ifdef MMIO_EN
      io_write   <= io_write_s;
      io_addr    <= io_addr_s;
      io_wdata   <= io_wdata_s;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases followed by random requests,
// checked against a transaction-level memory model kept in the bench.
`timescale 1ns/1ps

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MMIO_EN
  logic        io_write;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = 32'hC0DE_0001;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [0:16383];   // the RAM the DUT talks to
  logic [31:0] ref_mem [0:16383];   // expected contents, updated per transaction

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MMIO_EN
    , .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
`endif
  );

  // Falling-edge RAM: writes and reads are sampled on negedge.
  always @(negedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef MMIO_EN
    if (addr[31:10] == 22'h3FFFFF && size != 2'd2) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (addr[1:0] * 8)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (addr[1] * 16)) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] mask, sh;
    if (size == 2'd0) begin
      sh = addr[1:0] * 8;
      mask = 32'h0000_00FF << sh;
    end else if (size == 2'd1) begin
      sh = addr[1] * 16;
      mask = 32'h0000_FFFF << sh;
    end else begin
      sh = 32'd0;
      mask = 32'hFFFF_FFFF;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err, got_err, seen;
    logic [31:0] exp_rdata, got_rdata, new_word, wr_data;
    logic [13:0] idx, wr_addr;
    int          exp_lat, exp_wr, exp_rd, lat, n_wr, n_rd, both, busy_ready;

    idx       = addr[15:2];
    exp_err   = ref_err(size, addr);
    exp_rdata = 32'd0;
    new_word  = ref_mem[idx];
    if (exp_err) begin
      exp_lat = 1; exp_wr = 0; exp_rd = 0;
    end else if (!we) begin
      exp_lat = 2; exp_wr = 0; exp_rd = 1;
      exp_rdata = ref_load(ref_mem[idx], size, uns, addr);
    end else begin
      exp_lat = (size == 2'd2) ? 2 : 3; exp_wr = 1; exp_rd = (size == 2'd2) ? 0 : 1;
      new_word = ref_store(ref_mem[idx], size, addr, wdata);
    end

    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the DUT must ignore them.
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = $urandom_range(0, 3);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;

    lat = 1; seen = 1'b0; n_wr = 0; n_rd = 0; both = 0; busy_ready = 0;
    got_rdata = 32'hDEAD_BEEF; got_err = 1'bx; wr_data = 32'd0; wr_addr = 14'd0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        lat++;
      end
      if (mem_read && mem_write) both++;
      if (mem_read) n_rd++;
      if (mem_write) begin n_wr++; wr_data = mem_wdata; wr_addr = mem_addr; end
      if (req_ready) busy_ready++;
      if (resp_valid) begin seen = 1'b1; got_rdata = resp_rdata; got_err = resp_err; end
    end
    check("latency", lat, exp_lat);
    check("resp_err", {31'd0, got_err}, {31'd0, exp_err});
    check("resp_rdata", got_rdata, exp_rdata);
    check("mem_write_cnt", n_wr, exp_wr);
    check("mem_read_cnt", n_rd, exp_rd);
    check("rd_wr_overlap", both, 32'd0);
    check("ready_busy", busy_ready, 32'd0);
    if (exp_wr == 1) begin
      check("wr_addr", {18'd0, wr_addr}, {18'd0, idx});
      check("wr_data", wr_data, new_word);
      ref_mem[idx] = new_word;
    end
    @(posedge clk); #1;
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {29'd0, resp_valid, resp_err, mem_read}, 32'd0);
    check("rst_write", {31'd0, mem_write}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_maddr", {18'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
    check("ram_word4", ram[4], 32'h1234_5678);
    // Read-modify-write byte store.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hAABB_CCDD);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0011);
    check("sb_result", ref_mem[4], 32'h11BB_CCDD);
    check("ram_sb", ram[4], 32'h11BB_CCDD);
    // Sign/zero extension.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h80FF_7F01);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0022, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0023, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0);
    do_req(1'b0, 2'd2, 1'b1, 32'h0000_0020, 32'h0);
    // Illegal requests.
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0022, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0021, 32'hFFFF);
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'h5555_5555);
    check("ram_after_err", ram[8], 32'h80FF_7F01);

    // Reset during the RD phase of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0000_0010; req_wdata = 32'h0000_0099;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_rd", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0; #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("arst_maddr", {18'd0, mem_addr}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_nowrite", {31'd0, mem_write}, 32'd0);
    end
    rst_n = 1'b1;
    check("ram_untouched", ram[4], 32'h11BB_CCDD);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);

`ifdef MMIO_EN
    begin
      int n_io, n_mw;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'hFFFF_FC04;
      req_wdata = 32'h0000_DEAD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_io = 0; n_mw = 0;
      for (int c = 0; c < 4; c++) begin
        if (io_write) begin
          n_io++;
          check("io_addr", {22'd0, io_addr}, 32'h0000_0004);
          check("io_wdata", io_wdata, 32'h0000_DEAD);
        end
        if (mem_write) n_mw++;
        @(posedge clk); #1;
      end
      check("io_write_cnt", n_io, 32'd1);
      check("io_no_memwr", n_mw, 32'd0);
      do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FC04, 32'h0);
    end
`endif

    // Random traffic over a small window; upper address bits are noise.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 255) << 16) | $urandom_range(0, 63);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom);
    end
    for (int i = 0; i < 16; i++) check("final_ram", ram[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the CPU execute stage and the word-wide data RAM (the 14-bit-address, single write-enable, falling-edge RAM).
- Turns byte, halfword and word requests into word accesses.
- Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended.
- Misaligned and reserved-size requests are flagged and never reach memory.

Parameters:
- ADDR_W, 14, word-index width driven to RAM (mem_addr).
- DATA_W, 32, data width; only 32 supported.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend a sub-word load (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved size; valid with resp_valid.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write enable (to wea).
- mem_addr  out  ADDR_W  word index, req_addr[ADDR_W+1:2].
- mem_wdata  out  32  full word to RAM.
- mem_rdata  in  32  RAM read word; valid at the rising edge that ends the cycle in which mem_addr was driven.

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset: state = IDLE. req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Accept: accept on req_valid && req_ready. All request fields are registered at the accept edge and inputs are ignored afterwards.
- Alignment check: half needs addr[0]=0; word needs addr[1:0]=00.
- Transitions from IDLE on accept:
  - misaligned or size 11 -> RESP with err=1.
  - load -> RD.
  - word store -> WR.
  - sub-word store -> RD.
- RD:
  - mem_read=1 with mem_addr driven.
  - mem_rdata is captured into an internal word register at the end of the cycle.
  - Next state is RESP for a load, WR for a store.
- WR:
  - mem_write=1 for exactly one cycle, then RESP.
  - mem_wdata is req_wdata for a word store, otherwise the captured word with the target lane replaced.
  - Byte lane k=addr[1:0] takes bits 8k+7:8k. Half lane h=addr[1] takes bits 16h+15:16h. Little-endian.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in RD, WR and RESP.
- Load data:
  - Byte: byte lane k, sign- or zero-extended per req_unsigned.
  - Half: half lane h, extended likewise.
  - Word: passed through; req_unsigned is ignored.
- Latency in cycles after the accept edge to resp_valid: error 1, load 2, word store 2, sub-word store 3. Maximum throughput is one request per (latency+1) cycles.
- mem_read and mem_write are never both high. Neither is asserted for error requests.
- mem_addr holds its last value when idle.
- Reset asserted mid-operation: immediate return to IDLE and outputs go to reset values. A pending RMW is abandoned. A write is committed only if rst_n is still high at the RAM's sampling edge during WR.

Optional Feature:
- MMIO_EN defined:
  - Adds ports io_write (out 1), io_addr (out 10), io_wdata (out 32), io_rdata (in 32).
  - Requests with req_addr[31:10]=all ones go to IO, word size only; other sizes give err.
  - An IO store pulses io_write for one cycle in WR. An IO load samples io_rdata in RD.
  - mem_read and mem_write stay 0 for IO requests.
- MMIO_EN undefined:
  - No IO ports.
  - Upper address bits above ADDR_W+1 are ignored and every request goes to RAM.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum (IDLE, RD, WR, RESP).
  - MMIO_BASE = 32'hFFFF_FC00.
- One sub-module, lsu_align: purely combinational load extraction/extension and store lane merge, instantiated once.

Test Plan:
- Word store 0x1234_5678 to addr 0x10, then word load from 0x10 -> mem_write pulse with mem_addr=4; load resp_rdata=0x1234_5678, resp_valid 2 cycles after accept.
- Preload word 0xAABBCCDD; sb 0x11 to addr 0x13 -> RD then WR with mem_wdata=0x11BBCCDD; resp_valid 3 cycles after accept.
- Word 0x80FF7F01 at addr 0x20:
  - lb 0x21 -> 0x0000007F.
  - lb 0x22 -> 0xFFFFFFFF.
  - lbu 0x23 -> 0x00000080.
  - lh 0x22 -> 0xFFFF80FF.
  - lhu 0x22 -> 0x000080FF.
- lw at 0x22, sh at 0x21, size 11 -> resp_err=1 one cycle after accept; mem_read and mem_write never asserted.
- Deassert rst_n during RD of a sub-word store -> all outputs reset asynchronously, no mem_write, memory word unchanged, req_ready=1.
- MMIO_EN: sw 0xDEAD to 0xFFFFFC04 -> io_write pulse with io_addr=0x004 and no mem_write; lb to 0xFFFFFC04 -> resp_err=1.
